frame_sequencer: RTL and testbench
==================================

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 Parameter NUM_FRAMES, default 8: number of stored frames; legal range 1..256.
REQ-002 Parameter TIMEOUT, default 1023: maximum clocks to wait for rd_valid; legal range 1..65535.
REQ-003 Port clock, input, 1: the single clock; all logic on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port clock_cycle, input, 1: asynchronous rotation-sync input; each rising edge advances one frame.
REQ-006 Port rd_addr, output, 8: frame address to the frame store.
REQ-007 Port rd_req, output, 1: read request to the frame store; level signal.
REQ-008 Port rd_data, input, 256: frame bits from the frame store; valid only while rd_valid=1.
REQ-009 Port rd_valid, input, 1: one-clock acknowledge that rd_data holds the frame at rd_addr.
REQ-010 Port frame, output, 256: registered frame bits for the display matrix driver.
REQ-011 Port frame_strobe, output, 1: one-clock pulse; frame changed this cycle.
REQ-012 Port overrun, output, 8: saturating count of dropped advance events.
REQ-013 Port timeout_err, output, 8: saturating count of read timeouts.

Function
REQ-014 clock_cycle SHALL pass through a 2-flop synchronizer and a rising-edge detector.
REQ-015 The resulting one-clock advance pulse SHALL be asserted exactly 3 clocks after the first clock edge that samples clock_cycle=1.
REQ-016 The controller SHALL be an FSM with states IDLE, REQ and WAIT.
REQ-017 In IDLE, an advance pulse SHALL set rd_addr to rd_addr+1, or to 0 when rd_addr=NUM_FRAMES-1, and move the FSM to REQ.
REQ-018 rd_addr SHALL change only on an IDLE advance and SHALL never exceed NUM_FRAMES-1.
REQ-019 On entering REQ, rd_req SHALL be driven to 1 and the FSM SHALL move to WAIT the next clock; rd_req stays 1 throughout WAIT.
REQ-020 rd_req SHALL rise 1 clock after the advance pulse, and rd_addr SHALL be stable while rd_req=1.
REQ-021 In WAIT, rd_valid=1 SHALL load frame from rd_data, deassert rd_req and return the FSM to IDLE, all in the same clock edge.
REQ-022 frame_strobe SHALL be 1 for exactly the one clock in which the new frame value is first visible.
REQ-023 rd_valid in IDLE or REQ SHALL be ignored: no load, no strobe.
REQ-024 In WAIT, a 16-bit wait counter SHALL count clocks.
REQ-025 If the wait counter reaches TIMEOUT without rd_valid, the block SHALL deassert rd_req, keep frame unchanged, increment timeout_err (saturating at 255) and return to IDLE.
REQ-026 rd_valid in the same clock as the timeout condition SHALL take priority: frame loads and no error is counted.
REQ-027 An advance pulse during REQ or WAIT SHALL set a one-deep pending flag.
REQ-028 A further advance while the pending flag is set SHALL increment overrun (saturating at 255) and be discarded.
REQ-029 On return to IDLE with the pending flag set, the block SHALL clear the flag and perform the advance next clock, exactly as in REQ-017.
REQ-030 An advance pulse in the same clock as the IDLE return SHALL set the pending flag.
REQ-031 NUM_FRAMES=1 SHALL keep rd_addr at 0 while still re-fetching on every advance.

Reset
REQ-032 While reset=1 the block SHALL hold: rd_addr=0, rd_req=0, frame=all zeros, frame_strobe=0, overrun=0, timeout_err=0, synchronizer and edge flops=0, pending flag=0, wait counter=0, FSM=REQ.
REQ-033 On the first clock after reset deasserts, the block SHALL issue a boot fetch of frame 0: rd_req=1 with rd_addr=0.
REQ-034 Reset asserted mid-fetch SHALL abandon the fetch, with rd_req=0 on the next clock and no frame load or strobe.

Verification
REQ-035 Boot: release reset, return rd_valid 2 clocks after rd_req with rd_data=256'h1 -> rd_addr=0; frame=256'h1; frame_strobe is one clock wide.
REQ-036 Wrap: NUM_FRAMES=8, 9 clock_cycle pulses, each ≥4 clocks high and ≥4 low, each fetch acknowledged -> rd_addr sequence 1..7, 0, 1; each rd_req rises 4 clocks after the clock_cycle rising edge.
REQ-037 Pending/overrun: withhold rd_valid, apply 3 advances -> pending serviced after the ack; overrun=1; rd_addr advances by 2 in total.
REQ-038 Timeout: TIMEOUT=10, never assert rd_valid -> rd_req drops after 10 WAIT clocks; timeout_err=1; frame unchanged; next advance fetches normally.
REQ-039 Priority/ignore: rd_valid in the same clock as the timeout -> load, timeout_err unchanged; rd_valid pulsed in IDLE -> frame and frame_strobe unchanged.
REQ-040 Reset mid-WAIT: assert reset with rd_req=1 -> next clock rd_req=0, frame=0, counters=0, then a boot fetch of address 0 after release.

Source files
------------

// File: rtl/frame_sequencer.sv
// frame_sequencer
//   Fetches display frames from an external frame store, one frame per
//   rotation-sync edge, and presents the latest frame to the matrix driver.
//
// Parameters
//   NUM_FRAMES  - number of stored frames (1..256)
//   TIMEOUT     - maximum clocks to wait for rd_valid (1..65535)
//
// Ports
//   clock        - single clock, rising edge
//   reset        - synchronous, active-high reset
//   clock_cycle  - asynchronous rotation-sync input; each rising edge advances one frame
//   rd_addr      - frame address to the frame store
//   rd_req       - level read request to the frame store
//   rd_data      - frame bits from the frame store, valid while rd_valid=1
//   rd_valid     - one-clock acknowledge for rd_data
//   frame        - registered frame bits for the display matrix driver
//   frame_strobe - one-clock pulse in the cycle a new frame first appears
//   overrun      - saturating count of dropped advance events
//   timeout_err  - saturating count of read timeouts
module frame_sequencer #(
  parameter int unsigned NUM_FRAMES = 8,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clock_cycle,
  output logic [7:0]   rd_addr,
  output logic         rd_req,
  input  logic [255:0] rd_data,
  input  logic         rd_valid,
  output logic [255:0] frame,
  output logic         frame_strobe,
  output logic [7:0]   overrun,
  output logic [7:0]   timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [7:0]  LAST_ADDR  = 8'(NUM_FRAMES - 1);
  localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT);

  state_t      state;
  logic        cc_meta;
  logic        cc_sync;
  logic [1:0]  cc_hist;
  logic        advance;
  logic        pending;
  logic [15:0] wait_cnt;
  logic [15:0] wait_next;
  logic [7:0]  addr_next;

  // Two-flop synchronizer, then a registered edge detector. The extra
  // history flop places the advance pulse three clocks after the first
  // edge that samples clock_cycle high.
  always_ff @(posedge clock) begin
    if (reset) begin
      cc_meta <= 1'b0;
      cc_sync <= 1'b0;
      cc_hist <= '0;
      advance <= 1'b0;
    end else begin
      cc_meta <= clock_cycle;
      cc_sync <= cc_meta;
      cc_hist <= {cc_hist[0], cc_sync};
      advance <= cc_hist[0] & ~cc_hist[1];
    end
  end

  always_comb begin
    wait_next = wait_cnt + 16'd1;
    addr_next = (rd_addr == LAST_ADDR) ? '0 : rd_addr + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= REQ;   // leaving reset performs the boot fetch of frame 0
      rd_addr      <= '0;
      rd_req       <= 1'b0;
      frame        <= '0;
      frame_strobe <= 1'b0;
      overrun      <= '0;
      timeout_err  <= '0;
      pending      <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      frame_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (advance || pending) begin
            rd_addr <= addr_next;
            rd_req  <= 1'b1;
            state   <= REQ;
            // A fresh advance arriving while a pending one is serviced is kept.
            pending <= pending & advance;
          end
        end
        REQ, WAIT: begin
          if (advance) begin
            if (!pending) begin
              pending <= 1'b1;
            end else if (overrun != '1) begin
              overrun <= overrun + 8'd1;
            end
          end
          if (state == REQ) begin
            rd_req   <= 1'b1;
            wait_cnt <= '0;
            state    <= WAIT;
          end else if (rd_valid) begin
            // Acknowledge wins over a coincident timeout.
            frame        <= rd_data;
            frame_strobe <= 1'b1;
            rd_req       <= 1'b0;
            state        <= IDLE;
          end else if (wait_next == WAIT_LIMIT) begin
            rd_req <= 1'b0;
            state  <= IDLE;
            if (timeout_err != '1) begin
              timeout_err <= timeout_err + 8'd1;
            end
          end else begin
            wait_cnt <= wait_next;
          end
        end
        default: begin
          rd_req <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer
//   Directed bench for frame_sequencer (NUM_FRAMES=8, TIMEOUT=10): boot fetch,
//   address wrap, pending/overrun, timeout, ack/timeout priority, ignored
//   rd_valid in IDLE and reset in the middle of a fetch.
module tb_frame_sequencer;

  logic         clock;
  logic         reset;
  logic         clock_cycle;
  logic [7:0]   rd_addr;
  logic         rd_req;
  logic [255:0] rd_data;
  logic         rd_valid;
  logic [255:0] frame;
  logic         frame_strobe;
  logic [7:0]   overrun;
  logic [7:0]   timeout_err;

  int checks = 0;
  int errors = 0;

  frame_sequencer #(.NUM_FRAMES(8), .TIMEOUT(10)) dut (
    .clock        (clock),
    .reset        (reset),
    .clock_cycle  (clock_cycle),
    .rd_addr      (rd_addr),
    .rd_req       (rd_req),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .frame        (frame),
    .frame_strobe (frame_strobe),
    .overrun      (overrun),
    .timeout_err  (timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Steps until rd_req is seen, bounded; returns the number of clocks taken.
  task automatic wait_req(output int lat);
    lat = 0;
    while (lat < 20 && rd_req !== 1'b1) begin
      step();
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic [255:0] d;
    logic [255:0] held;

    reset = 1'b1;
    clock_cycle = 1'b0;
    rd_valid = 1'b0;
    rd_data = '0;
    repeat (3) step();

    // Reset state
    check("rst_addr", rd_addr, 0);
    check("rst_req", rd_req, 0);
    check("rst_frame", frame, 0);
    check("rst_strobe", frame_strobe, 0);
    check("rst_overrun", overrun, 0);
    check("rst_timeout", timeout_err, 0);

    // Boot fetch of frame 0, acknowledged two clocks after rd_req
    reset = 1'b0;
    step();
    check("boot_req", rd_req, 1);
    check("boot_addr", rd_addr, 0);
    step();
    rd_valid = 1'b1;
    rd_data = 256'h1;
    step();
    rd_valid = 1'b0;
    check("boot_frame", frame, 256'h1);
    check("boot_strobe", frame_strobe, 1);
    check("boot_req_drop", rd_req, 0);
    step();
    check("boot_strobe_end", frame_strobe, 0);
    check("boot_frame_hold", frame, 256'h1);

    // Wrap: nine advances, 6 clocks high / 5 low, each fetch acknowledged.
    // rd_req is first seen 5 falling edges after raising clock_cycle:
    // the first sampling edge plus 4 clocks.
    for (int i = 1; i <= 9; i++) begin
      clock_cycle = 1'b1;
      wait_req(lat);
      check("wrap_latency", 256'(lat), 5);
      check("wrap_addr", rd_addr, 256'(i % 8));
      step();
      clock_cycle = 1'b0;
      d = {8{32'h1000 + 32'(i)}};
      rd_valid = 1'b1;
      rd_data = d;
      step();
      rd_valid = 1'b0;
      check("wrap_frame", frame, d);
      check("wrap_strobe", frame_strobe, 1);
      repeat (4) step();
    end
    held = {8{32'h1009}};

    // rd_valid while IDLE is ignored
    rd_valid = 1'b1;
    rd_data = {8{32'hDEAD_BEEF}};
    step();
    rd_valid = 1'b0;
    check("idle_frame", frame, held);
    check("idle_strobe", frame_strobe, 0);

    // Pending/overrun: three advances 4 clocks apart, ack withheld until
    // after the third one. Edges P0..P16 relative to the first raise.
    clock_cycle = 1'b1; step(); step();           // P0 P1
    clock_cycle = 1'b0; step(); step();           // P2 P3
    clock_cycle = 1'b1; step();                   // P4: first fetch issued
    check("pend_req", rd_req, 1);
    check("pend_addr", rd_addr, 2);
    step();                                       // P5
    clock_cycle = 1'b0; step(); step();           // P6 P7
    clock_cycle = 1'b1; step(); step();           // P8 (pending set) P9
    clock_cycle = 1'b0; step(); step(); step();   // P10 P11 P12 (overrun)
    check("pend_overrun", overrun, 1);
    check("pend_still_req", rd_req, 1);
    d = {8{32'hCAFE_0001}};
    rd_valid = 1'b1;
    rd_data = d;
    step();                                       // P13: ack
    rd_valid = 1'b0;
    check("pend_frame", frame, d);
    check("pend_req_drop", rd_req, 0);
    step();                                       // P14: pending serviced
    check("pend_service_req", rd_req, 1);
    check("pend_service_addr", rd_addr, 3);
    step();                                       // P15
    held = {8{32'hCAFE_0002}};
    rd_valid = 1'b1;
    rd_data = held;
    step();
    rd_valid = 1'b0;
    check("pend_frame2", frame, held);
    check("pend_overrun_hold", overrun, 1);
    repeat (3) step();

    // Timeout: no ack, rd_req drops after 10 WAIT clocks
    clock_cycle = 1'b1;
    wait_req(lat);
    check("to_latency", 256'(lat), 5);
    check("to_addr", rd_addr, 4);
    for (int j = 1; j <= 10; j++) begin
      step();
      if (j == 4) clock_cycle = 1'b0;
    end
    check("to_req_before", rd_req, 1);
    step();
    check("to_req_drop", rd_req, 0);
    check("to_count", timeout_err, 1);
    check("to_frame_hold", frame, held);
    check("to_no_strobe", frame_strobe, 0);
    repeat (3) step();

    // Next advance fetches normally
    clock_cycle = 1'b1;
    wait_req(lat);
    check("after_to_addr", rd_addr, 5);
    step();
    clock_cycle = 1'b0;
    d = {8{32'h5555_AAAA}};
    rd_valid = 1'b1;
    rd_data = d;
    step();
    rd_valid = 1'b0;
    check("after_to_frame", frame, d);
    repeat (4) step();

    // Ack in the same clock as the timeout wins
    clock_cycle = 1'b1;
    wait_req(lat);
    check("prio_addr", rd_addr, 6);
    for (int j = 1; j <= 10; j++) begin
      step();
      if (j == 4) clock_cycle = 1'b0;
    end
    d = {8{32'h0F0F_1234}};
    rd_valid = 1'b1;
    rd_data = d;
    step();
    rd_valid = 1'b0;
    check("prio_frame", frame, d);
    check("prio_strobe", frame_strobe, 1);
    check("prio_timeout_hold", timeout_err, 1);
    check("prio_req_drop", rd_req, 0);
    repeat (4) step();

    // Reset in the middle of WAIT
    clock_cycle = 1'b1;
    wait_req(lat);
    check("mid_addr", rd_addr, 7);
    step();
    clock_cycle = 1'b0;
    reset = 1'b1;
    step();
    check("mid_req", rd_req, 0);
    check("mid_frame", frame, 0);
    check("mid_addr_rst", rd_addr, 0);
    check("mid_overrun", overrun, 0);
    check("mid_timeout", timeout_err, 0);
    check("mid_strobe", frame_strobe, 0);
    reset = 1'b0;
    step();
    check("mid_boot_req", rd_req, 1);
    check("mid_boot_addr", rd_addr, 0);
    step();
    d = {8{32'h7777_0000}};
    rd_valid = 1'b1;
    rd_data = d;
    step();
    rd_valid = 1'b0;
    check("mid_boot_frame", frame, d);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
